// File: rtl/led_pattern.sv
// led_pattern: parametrised LED pattern generator for the board LED bank.
// A prescaler produces a tick every DIV<<speed enabled cycles; on each tick
// the active pattern (ROTATE, BOUNCE, FILL, BLINK) either steps or, if the
// requested mode differs from the active one, reloads that mode's start state.
// All outputs are registered; tick is high in the cycle the new ledr appears.
module led_pattern #(
   parameter int unsigned WIDTH = 16,      // number of LEDs, 2..32
   parameter int unsigned DIV   = 5000000  // base prescaler period, >= 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic [1:0]       speed,
   output logic [WIDTH-1:0] ledr,
   output logic             tick,
   output logic [1:0]       mode_q
);

   typedef enum logic [1:0] {
      MODE_ROTATE = 2'd0,
      MODE_BOUNCE = 2'd1,
      MODE_FILL   = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   // Prescaler must reach (DIV<<3)-1 for the slowest speed setting.
   localparam int unsigned PCNT_W = $clog2(DIV << 3);
   // BOUNCE position spans 0..WIDTH-1, FILL count spans 0..WIDTH.
   localparam int unsigned POS_W  = $clog2(WIDTH);
   localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

   localparam logic [WIDTH-1:0] LED_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] LED_ALL  = {WIDTH{1'b1}};
   localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
   localparam logic [POS_W-1:0] POS_PEN  = POS_W'(WIDTH - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

   logic [PCNT_W-1:0] pcnt_q, pcnt_d;
   logic [PCNT_W-1:0] pcnt_limit;
   logic              tick_q, tick_d;
   logic [WIDTH-1:0]  ledr_q, ledr_d;
   logic [1:0]        mode_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              up_q, up_d;

   // Prescaler: count enabled cycles, wrap and tick at the speed-scaled limit.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned; an unassigned path would infer a latch.
      pcnt_d     = pcnt_q;
      tick_d     = 1'b0;
      pcnt_limit = PCNT_W'((DIV << speed) - 1);
      if (en) begin
         // >= rather than == so a speed decrease mid-count ticks at once.
         if (pcnt_q >= pcnt_limit) begin
            pcnt_d = '0;
            tick_d = 1'b1;
         end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
         end
      end
   end

   // Pattern engine: on a tick, reload on mode change, otherwise step the mode.
   always_comb begin
      ledr_d = ledr_q;
      mode_d = mode_q;
      pos_d  = pos_q;
      cnt_d  = cnt_q;
      up_d   = up_q;
      if (tick_d) begin
         if (mode != mode_q) begin
            // Entry into a new mode: its start state, no step, dir ignored.
            mode_d = mode;
            pos_d  = '0;
            cnt_d  = '0;
            up_d   = 1'b1;
            case (mode_e'(mode))
               MODE_ROTATE: ledr_d = LED_ONE;
               MODE_BOUNCE: ledr_d = LED_ONE;
               MODE_FILL:   ledr_d = '0;
               MODE_BLINK:  ledr_d = '0;
               default:     ledr_d = LED_ONE;
            endcase
         end else begin
            case (mode_e'(mode_q))
               MODE_ROTATE: begin
                  if (dir) begin
                     ledr_d = {ledr_q[0], ledr_q[WIDTH-1:1]};
                  end else begin
                     ledr_d = {ledr_q[WIDTH-2:0], ledr_q[WIDTH-1]};
                  end
               end
               MODE_BOUNCE: begin
                  // Turning at an end jumps straight to the neighbour so
                  // each end LED is lit for a single tick per sweep.
                  if (up_q) begin
                     if (pos_q == POS_LAST) begin
                        up_d  = 1'b0;
                        pos_d = POS_PEN;
                     end else begin
                        pos_d = pos_q + POS_ONE;
                     end
                  end else begin
                     if (pos_q == '0) begin
                        up_d  = 1'b1;
                        pos_d = POS_ONE;
                     end else begin
                        pos_d = pos_q - POS_ONE;
                     end
                  end
                  ledr_d = LED_ONE << pos_d;
               end
               MODE_FILL: begin
                  if (up_q) begin
                     if (cnt_q == CNT_FULL) begin
                        up_d  = 1'b0;
                        cnt_d = cnt_q - CNT_ONE;
                     end else begin
                        cnt_d = cnt_q + CNT_ONE;
                     end
                  end else begin
                     if (cnt_q == '0) begin
                        up_d  = 1'b1;
                        cnt_d = CNT_ONE;
                     end else begin
                        cnt_d = cnt_q - CNT_ONE;
                     end
                  end
                  // Thermometer code of cnt; a shift by WIDTH yields all ones.
                  ledr_d = ~(LED_ALL << cnt_d);
               end
               MODE_BLINK: begin
                  ledr_d = ~ledr_q;
               end
               default: begin
                  ledr_d = ledr_q;
               end
            endcase
         end
      end
   end

   // State registers with asynchronous reset to the ROTATE start state.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         pcnt_q <= '0;
         tick_q <= 1'b0;
         ledr_q <= LED_ONE;
         mode_q <= MODE_ROTATE;
         pos_q  <= '0;
         cnt_q  <= '0;
         up_q   <= 1'b1;
      end else begin
         pcnt_q <= pcnt_d;
         tick_q <= tick_d;
         ledr_q <= ledr_d;
         mode_q <= mode_d;
         pos_q  <= pos_d;
         cnt_q  <= cnt_d;
         up_q   <= up_d;
      end
   end

   assign ledr = ledr_q;
   assign tick = tick_q;

endmodule

// File: doc/led_pattern.md
# led_pattern

Parametrised LED pattern generator that drives the board LED bank from the top level. It is the successor to the fixed single-pattern running light. Pattern width and tick rate are parameters. Four runtime-selectable patterns, direction, speed and pause controls come from the slide switches. All outputs are registered, and every pattern update is aligned to an internal prescaler tick.

## Interface
- `WIDTH`, 16: number of LEDs driven; legal range 2..32.
- `DIV`, 5000000: base prescaler period in `clk` cycles; must be ≥ 2.
- `clk` input 1: single system clock; all state on the rising edge.
- `rst` input 1: reset, asynchronous and active-high; deassertion is synchronous to `clk` at the top level.
- `en` input 1: run enable. When 0, the prescaler and all pattern state freeze.
- `mode` input 2: requested pattern: 0 ROTATE, 1 BOUNCE, 2 FILL, 3 BLINK.
- `dir` input 1: ROTATE direction only: 0 rotates left (toward MSB), 1 rotates right.
- `speed` input 2: tick period is `DIV << speed` cycles (×1, ×2, ×4, ×8).
- `ledr` output `WIDTH`: LED pattern, registered.
- `tick` output 1: one-cycle pulse in the cycle a pattern step is applied.
- `mode_q` output 2: currently active mode, registered.

## Operation
**Prescaler**
- Counter `pcnt` is sized for `(DIV<<3)-1`.
- With `en`=1:
  - If `pcnt >= (DIV<<speed)-1`, then `pcnt` ← 0 and a tick occurs.
  - Otherwise `pcnt` increments.
- The `>=` compare handles a speed decrease mid-count: the tick fires on the next cycle and then wraps.
- With `en`=0, `pcnt` holds and no tick occurs.

**Mode change**
- `mode` is sampled only on a tick.
- If `mode != mode_q` on a tick:
  - `mode_q` ← `mode`.
  - The pattern loads the new mode's initial state instead of stepping.
- Initial states:
  - ROTATE: `ledr` = 1 (bit 0).
  - BOUNCE: pos = 0, up = 1, so `ledr` = 1.
  - FILL: cnt = 0, up = 1, so `ledr` = 0.
  - BLINK: `ledr` = 0.

**Per-tick step (mode unchanged)**
- **ROTATE**
  - `dir`=0: rotate left by 1; bit `WIDTH-1` wraps to bit 0.
  - `dir`=1: rotate right; bit 0 wraps to bit `WIDTH-1`.
  - `dir` is sampled each tick; a change reverses direction at that tick with no reload.
- **BOUNCE**
  - `ledr` = 1 << pos.
  - up and pos < `WIDTH-1`: pos+1.
  - up and pos = `WIDTH-1`: up ← 0, pos ← `WIDTH-2`.
  - down and pos > 0: pos−1.
  - down and pos = 0: up ← 1, pos ← 1.
  - End LEDs are therefore lit for exactly one tick per sweep.
- **FILL**
  - `ledr` = (1 << cnt) − 1, with cnt in 0..`WIDTH`; cnt = `WIDTH` gives all ones.
  - cnt is `$clog2(WIDTH+1)` bits wide.
  - Up: cnt+1 until cnt = `WIDTH`, then up ← 0 and cnt−1 on that tick.
  - Down: cnt−1 until 0, then up ← 1 and cnt+1.
  - The sequence is a triangle wave with period 2·`WIDTH` ticks.
- **BLINK**: `ledr` ← ~`ledr`, where `ledr` is all zeros or all ones.
- Internal pos/cnt/up registers belong to the active mode only. Unused ones may hold stale values; they are reinitialised on entry to their mode.

**Reset**
- `rst` high, at any time including mid-sweep, forces immediately:
  - `pcnt` = 0
  - `tick` = 0
  - `mode_q` = 0 (ROTATE)
  - `ledr` = 1
  - pos = 0, cnt = 0, up = 1
- The first tick after release occurs `DIV<<speed` cycles after the first enabled cycle.

## Timing
- `tick` is registered and asserted in the same cycle that `ledr` and `mode_q` show their new values.
- `tick` pulses once per `DIV<<speed` enabled cycles.
- The `en` falling edge takes effect in the same cycle: no tick while `en`=0.
- On re-enable, `pcnt` resumes from its held value.
- A mode change is visible on `ledr` at the first tick after `mode` changes. Latency is 1..`DIV<<speed` cycles, with no intermediate stepped value.
- Simultaneous mode change and direction change on one tick: the reload wins and `dir` is ignored for that tick.
- Changes to `mode`, `dir` or `speed` between ticks have no effect on `ledr`.

## Test plan
Bench parameters: `WIDTH`=8, `DIV`=4.
- **Reset:** assert `rst` mid-count with `ledr`=0x10 → same-cycle `ledr`=0x01, `mode_q`=0, `tick`=0. After release with `speed`=0, the first tick comes 4 cycles later and `ledr`=0x02.
- **ROTATE wrap:** `dir`=0 from 0x80 → 0x01 next tick. Switch `dir`=1 → 0x80 on the following tick. `speed`=2 gives ticks every 16 cycles.
- **BOUNCE:** set `mode`=1 → first tick `ledr`=0x01. Subsequent ticks give 0x02…0x80, 0x40…0x01, 0x02; 14-tick period.
- **FILL:** `mode`=2 → 0x00, 0x01, 0x03…0xFF, 0x7F…0x00, 0x01; 16-tick period.
- **Pause and speed drop:**
  - `en`=0 for 20 cycles: no tick, `pcnt` and `ledr` hold.
  - `speed` 3→0 while `pcnt`=20: tick on the next enabled cycle, then every 4 cycles.
- **BLINK and mid-period mode change:** BLINK toggles 0x00/0xFF each tick. Change `mode` 3→0 mid-period → `ledr` unchanged until the next tick, then 0x01 and `mode_q`=0.
